// File: rtl/sm83_alu.sv
// SM83 ALU: combinational 8-bit result/flag path plus the registered internal
// carry that chains a low-byte ADD into a high-byte ADC for 16-bit adds.
module sm83_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic       carry_capture,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] alu_op,
  input  logic [3:0] alu_flag_in,
  output logic [7:0] alu_out,
  output logic [3:0] alu_flag_out,
  output logic       internal_carry
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_ADC  = 5'b00001, OP_SUB  = 5'b00010, OP_SBC  = 5'b00011,
    OP_AND  = 5'b00100, OP_XOR  = 5'b00101, OP_OR   = 5'b00110, OP_CP   = 5'b00111,
    OP_RLC  = 5'b01000, OP_RRC  = 5'b01001, OP_RL   = 5'b01010, OP_RR   = 5'b01011,
    OP_SLA  = 5'b01100, OP_SRA  = 5'b01101, OP_SWAP = 5'b01110, OP_SRL  = 5'b01111,
    OP_DAA  = 5'b10000, OP_CPL  = 5'b10001, OP_SCF  = 5'b10010, OP_CCF  = 5'b10011,
    OP_CPYA = 5'b11000, OP_CPYB = 5'b11001, OP_INC  = 5'b11010, OP_DEC  = 5'b11011
  } alu_op_e;

  logic       cin, fz, fn, fh, fc;
  logic       add_cin, sub_cin;
  logic [8:0] sum, diff;
  logic [4:0] sum_lo, diff_lo;
  logic [7:0] daa_adj;
  logic       daa_c;

  assign cin = alu_flag_in[0];
  assign fz  = alu_flag_in[3];
  assign fn  = alu_flag_in[2];
  assign fh  = alu_flag_in[1];
  assign fc  = alu_flag_in[0];

  // Carry-in only participates for ADC/SBC; bit 4 / bit 8 of the widened
  // sums give half-carry/borrow and carry/borrow directly.
  assign add_cin = (alu_op == OP_ADC) && cin;
  assign sub_cin = (alu_op == OP_SBC) && cin;
  assign sum     = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, add_cin};
  assign sum_lo  = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, add_cin};
  assign diff    = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, sub_cin};
  assign diff_lo = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'd0, sub_cin};

  always_comb begin
    daa_adj = 8'h00;
    daa_c   = fc;
    if (!fn) begin
      if (fh || (alu_a[3:0] > 4'h9)) daa_adj[3:0] = 4'h6;
      if (fc || (alu_a > 8'h99)) begin
        daa_adj[7:4] = 4'h6;
        daa_c        = 1'b1;
      end
    end else begin
      if (fh) daa_adj[3:0] = 4'h6;
      if (fc) daa_adj[7:4] = 4'h6;
    end
  end

  always_comb begin
    alu_out      = alu_a;
    alu_flag_out = alu_flag_in;
    case (alu_op)
      OP_ADD, OP_ADC: begin
        alu_out      = sum[7:0];
        alu_flag_out = {sum[7:0] == 8'h00, 1'b0, sum_lo[4], sum[8]};
      end
      OP_SUB, OP_SBC, OP_CP: begin
        alu_out      = (alu_op == OP_CP) ? alu_a : diff[7:0];
        alu_flag_out = {diff[7:0] == 8'h00, 1'b1, diff_lo[4], diff[8]};
      end
      OP_AND: begin
        alu_out      = alu_a & alu_b;
        alu_flag_out = {(alu_a & alu_b) == 8'h00, 3'b010};
      end
      OP_XOR: begin
        alu_out      = alu_a ^ alu_b;
        alu_flag_out = {(alu_a ^ alu_b) == 8'h00, 3'b000};
      end
      OP_OR: begin
        alu_out      = alu_a | alu_b;
        alu_flag_out = {(alu_a | alu_b) == 8'h00, 3'b000};
      end
      OP_RLC:  begin alu_out = {alu_a[6:0], alu_a[7]}; alu_flag_out[0] = alu_a[7]; end
      OP_RRC:  begin alu_out = {alu_a[0], alu_a[7:1]}; alu_flag_out[0] = alu_a[0]; end
      OP_RL:   begin alu_out = {alu_a[6:0], cin};      alu_flag_out[0] = alu_a[7]; end
      OP_RR:   begin alu_out = {cin, alu_a[7:1]};      alu_flag_out[0] = alu_a[0]; end
      OP_SLA:  begin alu_out = {alu_a[6:0], 1'b0};     alu_flag_out[0] = alu_a[7]; end
      OP_SRA:  begin alu_out = {alu_a[7], alu_a[7:1]}; alu_flag_out[0] = alu_a[0]; end
      OP_SWAP: begin alu_out = {alu_a[3:0], alu_a[7:4]}; alu_flag_out[0] = 1'b0;   end
      OP_SRL:  begin alu_out = {1'b0, alu_a[7:1]};     alu_flag_out[0] = alu_a[0]; end
      OP_DAA: begin
        alu_out      = fn ? (alu_a - daa_adj) : (alu_a + daa_adj);
        alu_flag_out = {(fn ? (alu_a - daa_adj) : (alu_a + daa_adj)) == 8'h00, fn, 1'b0, daa_c};
      end
      OP_CPL: begin
        alu_out      = ~alu_a;
        alu_flag_out = {fz, 2'b11, fc};
      end
      OP_SCF:  alu_flag_out = {fz, 3'b001};
      OP_CCF:  alu_flag_out = {fz, 2'b00, ~fc};
      OP_CPYA: alu_out = alu_a;
      OP_CPYB: alu_out = alu_b;
      OP_INC: begin
        alu_out      = alu_a + 8'd1;
        alu_flag_out = {alu_a == 8'hFF, 1'b0, alu_a[3:0] == 4'hF, fc};
      end
      OP_DEC: begin
        alu_out      = alu_a - 8'd1;
        alu_flag_out = {alu_a == 8'h01, 1'b1, alu_a[3:0] == 4'h0, fc};
      end
      default: begin
        alu_out      = alu_a;
        alu_flag_out = alu_flag_in;
      end
    endcase
    // Shift/rotate group shares Z-from-result, N=0, H=0.
    if (alu_op[4:3] == 2'b01)
      alu_flag_out[3:1] = {alu_out == 8'h00, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset)              internal_carry <= 1'b0;
    else if (carry_capture) internal_carry <= alu_flag_out[0];
  end

endmodule

// File: tb/tb_sm83_alu.sv
// Directed-vector bench for sm83_alu: combinational op table plus the
// internal-carry capture/hold/reset sequences.
module tb_sm83_alu;
  logic       clk = 1'b0;
  logic       reset, carry_capture;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [4:0] alu_op;
  logic [3:0] alu_flag_in, alu_flag_out;
  logic       internal_carry;

  int n_checks = 0;
  int n_fail   = 0;

  sm83_alu dut (
    .clk(clk), .reset(reset), .carry_capture(carry_capture),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flag_in(alu_flag_in),
    .alu_out(alu_out), .alu_flag_out(alu_flag_out), .internal_carry(internal_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [7:0] a, b;
    logic [3:0] fin;
    logic [7:0] exp_out;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[$];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s flags: got %04b expected %04b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] fin,
                         input logic [7:0] eo, input logic [3:0] ef);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.fin = fin;
    v.exp_out = eo; v.exp_flags = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fin);
    alu_op = op; alu_a = a; alu_b = b; alu_flag_in = fin;
  endtask

  initial begin
    //        name       op        a      b      fin      out    flags
    add_vec("ADD",    5'b00000, 8'h3A, 8'hC6, 4'b0000, 8'h00, 4'b1011);
    add_vec("ADC",    5'b00001, 8'hFF, 8'h00, 4'b0001, 8'h00, 4'b1011);
    add_vec("SUB",    5'b00010, 8'h3E, 8'h3E, 4'b0000, 8'h00, 4'b1100);
    add_vec("SBC",    5'b00011, 8'h3B, 8'h2A, 4'b0001, 8'h10, 4'b0100);
    add_vec("CP",     5'b00111, 8'h3C, 8'h40, 4'b0000, 8'h3C, 4'b0101);
    add_vec("AND",    5'b00100, 8'h5A, 8'h3F, 4'b0000, 8'h1A, 4'b0010);
    add_vec("XOR",    5'b00101, 8'hFF, 8'hFF, 4'b0000, 8'h00, 4'b1000);
    add_vec("OR",     5'b00110, 8'h00, 8'h00, 4'b0111, 8'h00, 4'b1000);
    add_vec("RLC",    5'b01000, 8'h85, 8'h00, 4'b1110, 8'h0B, 4'b0001);
    add_vec("RRC",    5'b01001, 8'h01, 8'h00, 4'b0000, 8'h80, 4'b0001);
    add_vec("RL",     5'b01010, 8'h80, 8'h00, 4'b0001, 8'h01, 4'b0001);
    add_vec("RR",     5'b01011, 8'h01, 8'h00, 4'b0000, 8'h00, 4'b1001);
    add_vec("SLA",    5'b01100, 8'h80, 8'h00, 4'b0000, 8'h00, 4'b1001);
    add_vec("SRA",    5'b01101, 8'h8A, 8'h00, 4'b0001, 8'hC5, 4'b0000);
    add_vec("SWAP",   5'b01110, 8'hF0, 8'h00, 4'b0001, 8'h0F, 4'b0000);
    add_vec("SRL",    5'b01111, 8'h01, 8'h00, 4'b0000, 8'h00, 4'b1001);
    add_vec("DAA",    5'b10000, 8'h7D, 8'h00, 4'b0000, 8'h83, 4'b0000);
    add_vec("DAA_C",  5'b10000, 8'h9A, 8'h00, 4'b0000, 8'h00, 4'b1001);
    add_vec("DAA_N",  5'b10000, 8'h0A, 8'h00, 4'b0110, 8'h04, 4'b0100);
    add_vec("CPL",    5'b10001, 8'h35, 8'h00, 4'b1001, 8'hCA, 4'b1111);
    add_vec("SCF",    5'b10010, 8'h12, 8'h00, 4'b1110, 8'h12, 4'b1001);
    add_vec("CCF",    5'b10011, 8'h12, 8'h00, 4'b0111, 8'h12, 4'b0000);
    add_vec("COPY_A", 5'b11000, 8'h99, 8'h42, 4'b0101, 8'h99, 4'b0101);
    add_vec("COPY_B", 5'b11001, 8'h99, 8'h42, 4'b1010, 8'h42, 4'b1010);
    add_vec("INC",    5'b11010, 8'hFF, 8'h00, 4'b0001, 8'h00, 4'b1011);
    add_vec("DEC",    5'b11011, 8'h10, 8'h00, 4'b0000, 8'h0F, 4'b0110);
    add_vec("UNUSED", 5'b10100, 8'h77, 8'h11, 4'b0101, 8'h77, 4'b0101);
    add_vec("UNUSED2",5'b11111, 8'hA5, 8'h11, 4'b1010, 8'hA5, 4'b1010);

    reset = 1'b1; carry_capture = 1'b0;
    drive(5'b00000, 8'h00, 8'h00, 4'b0000);
    @(posedge clk); #1;
    chk1("reset_carry", internal_carry, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fin);
      #1;
      chk8(vecs[i].name, alu_out, vecs[i].exp_out);
      chk4(vecs[i].name, alu_flag_out, vecs[i].exp_flags);
    end

    // Low-byte ADD with carry out captured.
    @(negedge clk);
    drive(5'b00000, 8'hF0, 8'h20, 4'b0000);
    carry_capture = 1'b1;
    @(posedge clk); #1;
    chk1("capture_add_carry", internal_carry, 1'b1);

    // Hold for 3 cycles while the ALU shows C=0.
    carry_capture = 1'b0;
    drive(5'b00000, 8'h01, 8'h01, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk1("hold_carry", internal_carry, 1'b1);

    // High-byte ADC fed from the captured carry: 0x12+0x34+1.
    drive(5'b00001, 8'h12, 8'h34, {3'b000, internal_carry});
    #1;
    chk8("adc_chain", alu_out, 8'h47);
    chk4("adc_chain", alu_flag_out, 4'b0000);

    // Capturing a zero carry clears the register.
    @(negedge clk);
    drive(5'b00000, 8'h01, 8'h01, 4'b0000);
    carry_capture = 1'b1;
    @(posedge clk); #1;
    chk1("capture_zero", internal_carry, 1'b0);

    // Re-arm, then reset wins over a simultaneous capture of C=1.
    @(negedge clk);
    drive(5'b00000, 8'hF0, 8'h20, 4'b0000);
    @(posedge clk); #1;
    chk1("rearm_carry", internal_carry, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk1("reset_over_capture", internal_carry, 1'b0);
    reset = 1'b0; carry_capture = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sm83_alu.md
# sm83_alu

The SM83 (Game Boy CPU) arithmetic/logic unit sits between the register-file read ports and the writeback/flag path of the CPU datapath. It has two parts:
- A combinational 8-bit ALU computing a result and the Z/N/H/C flags for one 5-bit operation code.
- A one-bit internal-carry register, which lets 16-bit additions be done as a low-byte ADD followed by a high-byte ADC.

## Interface
Parameters: none.
- clk  in  1  system clock. Single clock; the register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- carry_capture  in  1  when high at a rising edge, internal_carry loads alu_flag_out[0]. The controller asserts this on the last T-cycle of an M-cycle.
- alu_a  in  8  operand A.
- alu_b  in  8  operand B.
- alu_op  in  5  operation code.
- alu_flag_in  in  4  incoming flags {Z,N,H,C}: bit3=Z, bit2=N, bit1=H, bit0=C.
- alu_out  out  8  result; combinational.
- alu_flag_out  out  4  result flags {Z,N,H,C}; combinational.
- internal_carry  out  1  registered carry; reset value 0.

## Operation
Notation: cin = alu_flag_in[0]. Z = (alu_out == 0) unless stated otherwise. "keep" means the flag is copied from alu_flag_in.

00xxx instruction ALU group (encoding matches opcode bits 5:3):
- 00000 ADD: A+B. N=0, H = carry out of bit 3, C = carry out of bit 7.
- 00001 ADC: A+B+cin. N=0; H and C include cin.
- 00010 SUB: A−B. N=1, H = borrow from bit 4, C = borrow (A<B).
- 00011 SBC: A−B−cin. N=1; H and C include cin.
- 00100 AND: Z, N=0, H=1, C=0.
- 00101 XOR: Z, N=0, H=0, C=0.
- 00110 OR: Z, N=0, H=0, C=0.
- 00111 CP: flags exactly as SUB; alu_out = A (unchanged).

01xxx shift/rotate group, operand A. All set Z from the result, N=0, H=0.
- 01000 RLC: result {A[6:0],A[7]}, C=A[7].
- 01001 RRC: result {A[0],A[7:1]}, C=A[0].
- 01010 RL: result {A[6:0],cin}, C=A[7].
- 01011 RR: result {cin,A[7:1]}, C=A[0].
- 01100 SLA: result {A[6:0],0}, C=A[7].
- 01101 SRA: result {A[7],A[7:1]}, C=A[0].
- 01110 SWAP: result {A[3:0],A[7:4]}, C=0.
- 01111 SRL: result {0,A[7:1]}, C=A[0].

10xxx misc group:
- 10000 DAA: standard SM83 decimal adjust of A, using N, H and C from alu_flag_in.
  - N=0: add 0x06 if H or A[3:0]>9; add 0x60 and set C if C or A>0x99.
  - N=1: subtract 0x06 if H; subtract 0x60 if C.
  - Flags: Z from result, N keep, H=0, C as computed (C stays set if it was set).
- 10001 CPL: result ~A. Z keep, N=1, H=1, C keep.
- 10010 SCF: result A. Z keep, N=0, H=0, C=1.
- 10011 CCF: result A. Z keep, N=0, H=0, C=~cin.

11xxx copy/increment group:
- 11000 COPY_A: result A, flags = alu_flag_in.
- 11001 COPY_B: result B, flags = alu_flag_in.
- 11010 INC: result A+1 (wraps). Z, N=0, H=(A[3:0]==0xF), C keep.
- 11011 DEC: result A−1 (wraps). Z, N=1, H=(A[3:0]==0x0), C keep.

Other codes:
- Every other code (10100–10111, 11100–11111): result A, flags = alu_flag_in.
- No output may be inferred as a latch for any code.

Common rules:
- All arithmetic is modulo 256.
- The flag-update policy (which flags the CPU actually commits, forcing Z=0, etc.) belongs to the surrounding datapath, not this block.

## Timing
- alu_out and alu_flag_out are purely combinational from alu_a, alu_b, alu_op and alu_flag_in. Zero latency; no dependence on clk.
- internal_carry updates at a rising clk edge:
  - reset=1: it becomes 0. Reset takes priority over carry_capture.
  - reset=0 and carry_capture=1: it loads the current alu_flag_out[0].
  - Otherwise: it holds its value.
- A 16-bit add takes two steps:
  - Cycle n: op ADD with carry_capture=1.
  - Cycle n+1: op ADC with alu_flag_in[0] driven from internal_carry by the datapath.
- Asserting reset in the middle of this sequence discards the captured carry.

## Test plan
- ADD 0x3A+0xC6 → out 0x00, flags Z=1 N=0 H=1 C=1. ADC 0xFF+0x00 with cin=1 → 0x00, flags 1011.
- SUB 0x3E−0x3E → 0x00, flags 1100. SBC 0x3B−0x2A with cin=1 → 0x10, flags 0100. CP 0x3C vs 0x40 → out 0x3C, flags 0101.
- AND 0x5A&0x3F → 0x1A, flags 0010. XOR 0xFF^0xFF → 0x00, flags 1000. OR 0x00|0x00 → 0x00, flags 1000.
- Shift/rotate group:
  - RLC 0x85 → 0x0B, C=1.
  - RR 0x01 with cin=0 → 0x00, flags 1001.
  - SRA 0x8A → 0xC5, C=0.
  - SWAP 0xF0 → 0x0F, flags 0000.
- Misc and increment group:
  - DAA with A=0x7D, N=0, H=0, C=0 → 0x83, C=0.
  - CPL 0x35 → 0xCA.
  - INC 0xFF → 0x00, flags Z=1 H=1 with C kept.
  - DEC 0x10 → 0x0F, H=1 N=1.
  - COPY_B 0x42 → 0x42, flags unchanged.
- Carry register:
  - Reset → internal_carry=0.
  - ADD 0xF0+0x20 with carry_capture=1 → internal_carry=1 after the edge.
  - carry_capture=0 for 3 cycles → internal_carry holds 1.
  - reset together with carry_capture → internal_carry=0.
